// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT twiddle/butterfly address generator.
package ntt_pkg;

  localparam int unsigned NttLogn = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } ntt_state_e;

  // k is scaled by this so every stage indexes one N/2-entry twiddle ROM.
  function automatic int unsigned tw_shift(input int unsigned logn, input int unsigned s);
    return logn - 1 - s;
  endfunction

endpackage

// File: rtl/ntt_bf_counter.sv
// Nested k/j/s butterfly counter producing operand addresses and twiddle index.
module ntt_bf_counter
  import ntt_pkg::*;
#(
  parameter int unsigned LOGN   = NttLogn,
  parameter int unsigned STAGES = LOGN
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             rev,
  input  logic                             step,
  output logic [LOGN-1:0]                  addr_a,
  output logic [LOGN-1:0]                  addr_b,
  output logic [LOGN-1:0]                  tw_idx,
  output logic [$clog2(STAGES+1)-1:0]      stage,
  output logic                             last_stage,
  output logic                             last_xform
);

  localparam int unsigned SW = $clog2(STAGES + 1);
  localparam logic [SW-1:0] SFirst = '0;
  localparam logic [SW-1:0] SLast  = SW'(STAGES - 1);

  logic [LOGN-1:0] k_q, k_d, j_q, j_d, k_max, j_max;
  logic [SW-1:0]   s_q, s_d;
  logic            rev_q, rev_d;
  logic            last_k, last_j, s_end;

  always_comb begin
    k_max      = (LOGN'(1) << s_q) - LOGN'(1);
    j_max      = (LOGN'(1) << tw_shift(LOGN, 32'(s_q))) - LOGN'(1);
    last_k     = (k_q == k_max);
    last_j     = (j_q == j_max);
    s_end      = rev_q ? (s_q == SFirst) : (s_q == SLast);
    last_stage = last_k && last_j;
    last_xform = last_stage && s_end;
    addr_a     = (j_q << (32'(s_q) + 1)) + k_q;
    addr_b     = addr_a + (LOGN'(1) << s_q);
    tw_idx     = k_q << tw_shift(LOGN, 32'(s_q));
    stage      = s_q;
  end

  always_comb begin
    k_d   = k_q;
    j_d   = j_q;
    s_d   = s_q;
    rev_d = rev_q;
    if (clear) begin
      k_d   = '0;
      j_d   = '0;
      rev_d = rev;
      s_d   = rev ? SLast : SFirst;
    end else if (step) begin
      if (!last_k) begin
        k_d = k_q + LOGN'(1);
      end else begin
        k_d = '0;
        if (!last_j) begin
          j_d = j_q + LOGN'(1);
        end else begin
          j_d = '0;
          if (s_end)      s_d = rev_q ? SLast : SFirst;
          else if (rev_q) s_d = s_q - SW'(1);
          else            s_d = s_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      j_q   <= '0;
      s_q   <= '0;
      rev_q <= 1'b0;
    end else begin
      k_q   <= k_d;
      j_q   <= j_d;
      s_q   <= s_d;
      rev_q <= rev_d;
    end
  end

endmodule

// File: rtl/ntt_tw_addr_gen.sv
// NTT twiddle-ROM and butterfly address generator with a stallable output stage.
// Optional inverse (descending-stage) order via NTT_TW_ADDR_GEN_INTT_EN.
module ntt_tw_addr_gen
  import ntt_pkg::*;
#(
  parameter int unsigned LOGN   = NttLogn,
  parameter int unsigned STAGES = LOGN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
`ifdef NTT_TW_ADDR_GEN_INTT_EN
  input  logic                        inverse,
`endif
  input  logic                        out_ready,
  output logic [LOGN-1:0]             tw_raddr,
  output logic                        out_valid,
  output logic [LOGN-1:0]             addr_a,
  output logic [LOGN-1:0]             addr_b,
  output logic [$clog2(STAGES+1)-1:0] stage,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned SW = $clog2(STAGES + 1);

  ntt_state_e      state_q, state_d;
  logic            advance, clear, step, load, rev;
  logic            valid_q, valid_d, done_q, done_d, last_q;
  logic [LOGN-1:0] cnt_a, cnt_b, cnt_tw, a_q, b_q, tw_q;
  logic [SW-1:0]   cnt_stage, stage_q;
  logic            cnt_last_stage, cnt_last_xform;

`ifdef NTT_TW_ADDR_GEN_INTT_EN
  assign rev = inverse;
`else
  assign rev = 1'b0;
`endif

  ntt_bf_counter #(
    .LOGN  (LOGN),
    .STAGES(STAGES)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .rev       (rev),
    .step      (step),
    .addr_a    (cnt_a),
    .addr_b    (cnt_b),
    .tw_idx    (cnt_tw),
    .stage     (cnt_stage),
    .last_stage(cnt_last_stage),
    .last_xform(cnt_last_xform)
  );

  assign advance = !valid_q || out_ready;

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    step    = 1'b0;
    load    = 1'b0;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // done_q still high means we are in the completion cycle: ignore start.
        if (start && !done_q) begin
          clear   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (advance) begin
          load    = 1'b1;
          step    = 1'b1;
          valid_d = 1'b1;
          if (cnt_last_xform) state_d = StFlush;
        end
      end
      StFlush: begin
        if (out_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
      stage_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (load) begin
        a_q     <= cnt_a;
        b_q     <= cnt_b;
        tw_q    <= cnt_tw;
        stage_q <= cnt_stage;
        last_q  <= cnt_last_stage;
      end
    end
  end

  // While stalled the ROM re-reads the held index so its output stays aligned.
  assign tw_raddr  = advance ? cnt_tw : tw_q;
  assign out_valid = valid_q;
  assign addr_a    = a_q;
  assign addr_b    = b_q;
  assign stage     = stage_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle) || done_q;

endmodule

// File: tb/tb_ntt_tw_addr_gen.sv
// Scoreboard bench for ntt_tw_addr_gen (LOGN=3) with a 1-cycle twiddle ROM model downstream.
module tb_ntt_tw_addr_gen;

  localparam int unsigned LOGN   = 3;
  localparam int unsigned STAGES = 3;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] tw;
    logic [1:0] stg;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;
`ifdef NTT_TW_ADDR_GEN_INTT_EN
  logic       inverse = 1'b0;
`endif
  logic [2:0] tw_raddr, addr_a, addr_b;
  logic [1:0] stage;
  logic       out_valid, out_last, busy, done;
  logic [31:0] rom_b = '0;

  int errors = 0;
  int checks = 0;
  int beats_seen = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_acc = 0;
  beat_t exp_q[$];
  beat_t mon_e;

  int fa[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int fb[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int ftw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  always #5 clk = ~clk;

  ntt_tw_addr_gen #(
    .LOGN  (LOGN),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef NTT_TW_ADDR_GEN_INTT_EN
    .inverse  (inverse),
`endif
    .out_ready(out_ready),
    .tw_raddr (tw_raddr),
    .out_valid(out_valid),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .stage    (stage),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [31:0] rom_val(input logic [2:0] i);
    return {29'd0, i} << 23;
  endfunction

  always @(posedge clk) rom_b <= rom_val(tw_raddr);
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_seq(input bit rev);
    beat_t e;
    int f;
    for (int i = 0; i < 12; i++) begin
      f      = rev ? (2 - i / 4) * 4 + i % 4 : i;
      e.a    = 3'(fa[f]);
      e.b    = 3'(fb[f]);
      e.tw   = 3'(ftw[f]);
      e.stg  = rev ? 2'(2 - i / 4) : 2'(i / 4);
      e.last = (i % 4 == 3);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q[0];
          check(out_ready ? "beat" : "stall_hold",
                {addr_a, addr_b, stage, out_last, rom_b},
                {mon_e.a, mon_e.b, mon_e.stg, mon_e.last, rom_val(mon_e.tw)});
          if (out_ready) begin
            void'(exp_q.pop_front());
            beats_seen++;
            if (exp_q.size() == 0) last_acc = cyc;
          end
        end
      end
      if (done) begin
        done_cnt++;
        check("done_busy", 64'(busy), 64'd1);
        check("done_delay", 64'(cyc - last_acc), 64'd1);
      end
    end
  end

  task automatic run_xform(input int stall_at, input int restart_at);
    int  base, n;
    bit  stalled, restarted;
    base       = done_cnt;
    beats_seen = 0;
    n          = 0;
    stalled    = 0;
    restarted  = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("lat_busy_novalid", {62'd0, busy, out_valid}, 64'b10);
    @(posedge clk); #1;
    check("lat_first_valid", 64'(out_valid), 64'd1);
    while (done_cnt == base && n < 100) begin
      if (beats_seen == stall_at && !stalled) begin
        stalled   = 1;
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
          check("stall_raddr", 64'(tw_raddr), 64'(exp_q[0].tw));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      if (beats_seen == restart_at && !restarted) begin
        restarted = 1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    check("done_seen", 64'(done_cnt != base), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", 64'(done_cnt - base), 64'd1);
    check("beat_count", 64'(beats_seen), 64'd12);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("idle_after", {62'd0, busy, out_valid}, 64'd0);
  endtask

  initial begin
    int n;
    #1;
    check("reset_outputs", {out_valid, done, busy, out_last, addr_a, addr_b, stage, tw_raddr},
          64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    push_seq(0);
    run_xform(-1, -1);

    push_seq(0);
    run_xform(5, -1);

    push_seq(0);
    run_xform(-1, 5);

    // Reset in the middle of a transform.
    push_seq(0);
    beats_seen = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (beats_seen < 7 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_beat7", 64'(beats_seen), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset", {out_valid, done, busy, out_last, addr_a, addr_b, stage, tw_raddr},
          64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_seq(0);
    run_xform(-1, -1);

`ifdef NTT_TW_ADDR_GEN_INTT_EN
    inverse = 1'b1;
    push_seq(1);
    run_xform(-1, -1);
    inverse = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ntt_tw_addr_gen.md
NTT_TW_ADDR_GEN -- requirements
Module: ntt_tw_addr_gen

Interface
REQ-001 The block SHALL have parameter LOGN, default 3, meaning log2 of transform size N.
REQ-002 The block SHALL have parameter STAGES, default LOGN, meaning the number of butterfly stages executed.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: pulse that begins a transform when idle.
REQ-006 The block SHALL have port out_ready, input, 1 bit: the downstream butterfly accepts the current beat.
REQ-007 The block SHALL have port tw_raddr, output, LOGN bits: the twiddle ROM read address, fed to the ROM raddr input.
REQ-008 The block SHALL have port out_valid, output, 1 bit: addr_a, addr_b, stage and out_last are valid and aligned with the ROM output b.
REQ-009 The block SHALL have ports addr_a and addr_b, output, LOGN bits each: the butterfly operand addresses.
REQ-010 The block SHALL have port stage, output, clog2(STAGES+1) bits: the stage index of the current beat.
REQ-011 The block SHALL have port out_last, output, 1 bit: marks the last butterfly of a stage.
REQ-012 The block SHALL have ports busy and done, output, 1 bit each: busy is high while running; done is a one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FLUSH; the transitions SHALL be:
- IDLE to RUN on start.
- RUN to FLUSH when the final beat is loaded into the output stage.
- FLUSH to IDLE when that beat is accepted.
REQ-014 The counters SHALL be stage s, group j and index k; with half = 2^s:
- addr_a = j*2*half + k
- addr_b = addr_a + half
- twiddle index = k << (LOGN-1-s), MSB zero
- k is the inner loop (0..half-1), j is the outer loop (0..N/(2*half)-1), s ascends from 0.
REQ-015 Each stage SHALL be exactly N/2 beats, and a transform SHALL be STAGES*N/2 beats.
REQ-016 The advance condition SHALL be advance = !out_valid || out_ready; the output stage loads and the counters step only on advance.
REQ-017 On advance, tw_raddr SHALL equal the counter twiddle index; otherwise it SHALL equal a held copy of the twiddle index of the beat in the output stage. This keeps the 1-cycle ROM output b aligned through stalls.
REQ-018 Latency SHALL be as follows: start in IDLE produces the first out_valid 2 cycles later; with out_ready held high there is one beat per cycle and no bubbles, including across stage boundaries.
REQ-019 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-020 done SHALL pulse one cycle after the final beat is accepted; busy SHALL be high from the cycle after start until done inclusive.
REQ-021 start SHALL be ignored while busy; start coinciding with done SHALL also be ignored.
REQ-022 All counter arithmetic SHALL be unsigned and wrap-free; k, j and s SHALL reset to 0 at their limits, and the counters SHALL never index beyond N-1.

Reset
REQ-023 rst_n low SHALL immediately clear everything: FSM to IDLE, counters to 0, and out_valid, done, busy, out_last, addr_a, addr_b, stage and tw_raddr to 0.
REQ-024 A reset mid-transform SHALL abandon it; the next start SHALL begin a fresh transform from s=0.

Configuration
REQ-025 With macro NTT_TW_ADDR_GEN_INTT_EN defined:
- An input inverse, 1 bit, is sampled on start.
- When inverse=1, stages run in descending order, s = STAGES-1 down to 0 (Gentleman-Sande order), using the same address and twiddle formulas with that s.
REQ-026 Without NTT_TW_ADDR_GEN_INTT_EN, the inverse port SHALL be absent and only the forward order SHALL be generated.

Structure
REQ-027 A shared package ntt_pkg SHALL hold the FSM state typedef, the LOGN default, and a function computing the twiddle shift.
REQ-028 The nested k/j/s counter SHALL be one sub-module, ntt_bf_counter, with step input and last-of-stage and last-of-transform outputs; the FSM and output stage SHALL reside in ntt_tw_addr_gen.

Verification
REQ-029 The bench SHALL cover the following directed scenarios (LOGN=3, ROM instantiated downstream):
- Forward ordering: start with out_ready=1 gives 12 beats of (a,b,tw):
  - s0: (0,1,0), (2,3,0), (4,5,0), (6,7,0)
  - s1: (0,2,0), (1,3,2), (4,6,0), (5,7,2)
  - s2: (0,4,0), (1,5,1), (2,6,2), (3,7,3)
  - done is pulsed once.
- Twiddle alignment: on the s2 beat (2,6), ROM b = 16777216 in the same cycle out_valid is high.
- Stall: drop out_ready for 3 cycles on the s1 beat (1,3): outputs and b hold (b=16777216 from raddr 2), then the sequence resumes with no dropped or duplicated beats.
- Start-while-busy: a second start at beat 5 is ignored; total beats stay 12 and done is single.
- Reset mid-run: assert rst_n low at beat 7; all outputs go to 0 asynchronously; a new start replays from (0,1,0).
- With NTT_TW_ADDR_GEN_INTT_EN and inverse=1: the first beat is (0,4,0) and the last beat is (6,7,0).
